// File: rtl/dark_pkg.sv
// Shared constants and helpers for the dark-channel pipeline blocks.
// Compare helpers work on a fixed wide word so any DATA_W up to MAX_DATA_W can reuse them.
package dark_pkg;

  localparam int DATA_W     = 8;
  localparam int MAX_WIN    = 15;
  localparam int MAX_DATA_W = 32;

  function automatic logic [MAX_DATA_W-1:0] all_ones(input int width);
    logic [MAX_DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      if (i < width) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Callers zero-extend narrower values, which leaves the unsigned ordering intact.
  function automatic logic [MAX_DATA_W-1:0] min2(input logic [MAX_DATA_W-1:0] a,
                                                 input logic [MAX_DATA_W-1:0] b);
    return (b < a) ? b : a;
  endfunction

  function automatic int node_count(input int leaves, input int level);
    return (leaves + (1 << level) - 1) >> level;
  endfunction

endpackage

// File: rtl/chan_min.sv
// Combinational minimum across the CH_N channels of one packed pixel.
module chan_min #(
  parameter int DATA_W = dark_pkg::DATA_W,
  parameter int CH_N   = 3
) (
  input  logic [CH_N*DATA_W-1:0] pix,
  output logic [DATA_W-1:0]      pix_min
);
  import dark_pkg::*;

  always_comb begin
    logic [MAX_DATA_W-1:0] acc;
    acc = MAX_DATA_W'(pix[0 +: DATA_W]);
    for (int k = 1; k < CH_N; k++) begin
      acc = min2(acc, MAX_DATA_W'(pix[k*DATA_W +: DATA_W]));
    end
    pix_min = acc[DATA_W-1:0];
  end

endmodule

// File: rtl/dark_channel_hmin.sv
// Horizontal dark-channel pass: per-pixel channel minimum followed by a trailing
// WIN-pixel sliding minimum that restarts whenever de drops.
module dark_channel_hmin #(
  parameter int DATA_W = dark_pkg::DATA_W,
  parameter int CH_N   = 3,
  parameter int WIN    = 5
) (
  input  logic                   pixelclk,
  input  logic                   reset_n,
  input  logic [CH_N*DATA_W-1:0] i_pix,
  input  logic                   i_hsync,
  input  logic                   i_vsync,
  input  logic                   i_de,
  input  logic                   i_win_en,
  output logic [DATA_W-1:0]      o_dark,
  output logic                   o_hsync,
  output logic                   o_vsync,
  output logic                   o_de
);
  import dark_pkg::*;

  localparam int HIST_N = (WIN > 1) ? WIN - 1 : 1;
  localparam int LEVELS = $clog2(WIN);
  localparam logic [MAX_DATA_W-1:0] ONES_WIDE = all_ones(DATA_W);
  localparam logic [DATA_W-1:0]     ONES      = ONES_WIDE[DATA_W-1:0];

  if (WIN < 1 || WIN > MAX_WIN) begin : g_bad_win
    $error("dark_channel_hmin: WIN must be in 1..15");
  end
  if (CH_N < 2 || CH_N > 4) begin : g_bad_ch
    $error("dark_channel_hmin: CH_N must be in 2..4");
  end
  if (DATA_W < 1 || DATA_W > MAX_DATA_W) begin : g_bad_dw
    $error("dark_channel_hmin: DATA_W out of range");
  end

  function automatic logic [DATA_W-1:0] min_w(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    logic [MAX_DATA_W-1:0] t;
    t = min2(MAX_DATA_W'(a), MAX_DATA_W'(b));
    return t[DATA_W-1:0];
  endfunction

  logic [DATA_W-1:0] pix_min;
  logic [DATA_W-1:0] s1_min;
  logic              s1_de, s1_hs, s1_vs, s1_win;
  logic [DATA_W-1:0] hist [HIST_N];
  logic [DATA_W-1:0] win_min;

  chan_min #(
    .DATA_W (DATA_W),
    .CH_N   (CH_N)
  ) u_chan_min (
    .pix     (i_pix),
    .pix_min (pix_min)
  );

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      s1_min <= '0;
      s1_de  <= 1'b0;
      s1_hs  <= 1'b0;
      s1_vs  <= 1'b0;
      s1_win <= 1'b0;
    end else begin
      s1_min <= pix_min;
      s1_de  <= i_de;
      s1_hs  <= i_hsync;
      s1_vs  <= i_vsync;
      s1_win <= i_win_en;
    end
  end

  // All-ones history never wins a compare, so a cleared history behaves like "no pixels yet".
  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < HIST_N; k++) hist[k] <= ONES;
    end else if (!s1_de) begin
      for (int k = 0; k < HIST_N; k++) hist[k] <= ONES;
    end else begin
      hist[0] <= s1_min;
      for (int k = 1; k < HIST_N; k++) hist[k] <= hist[k-1];
    end
  end

  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int N = node_count(WIN, l);
    logic [DATA_W-1:0] node [N];
    if (l == 0) begin : g_leaf
      assign node[0] = s1_min;
      for (genvar k = 1; k < WIN; k++) begin : g_h
        assign node[k] = hist[k-1];
      end
    end else begin : g_cmp
      localparam int P = node_count(WIN, l - 1);
      for (genvar i = 0; i < N; i++) begin : g_n
        if (2*i + 1 < P) begin : g_pair
          assign node[i] = min_w(g_lvl[l-1].node[2*i], g_lvl[l-1].node[2*i+1]);
        end else begin : g_pass
          assign node[i] = g_lvl[l-1].node[2*i];
        end
      end
    end
  end

  assign win_min = g_lvl[LEVELS].node[0];

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      o_dark  <= '0;
      o_de    <= 1'b0;
      o_hsync <= 1'b0;
      o_vsync <= 1'b0;
    end else begin
      o_de    <= s1_de;
      o_hsync <= s1_hs;
      o_vsync <= s1_vs;
      if (!s1_de) begin
        o_dark <= '0;
      end else if (s1_win && (WIN > 1)) begin
        o_dark <= win_min;
      end else begin
        o_dark <= s1_min;
      end
    end
  end

endmodule

// File: doc/dark_channel_hmin.md
Name: dark_channel_hmin

Overview:
- Parametrised successor to the per-pixel RGB minimum block in the video pipeline.
- Reduces CH_N channels per pixel to their minimum, then takes the sliding minimum over the last WIN pixels of the same line (the horizontal dark-channel pass).
- Delays hsync/vsync/de to match the data latency.
- Sits between the pixel source and the dehaze stage. Per-pixel-only mode is runtime selectable.

Parameters:
- DATA_W, 8, bits per channel.
- CH_N, 3, channels per pixel (2..4). Channel k occupies i_pix[k*DATA_W +: DATA_W].
- WIN, 5, horizontal window length in pixels (1..15).

Ports:
- pixelclk  in  1  pixel clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_pix  in  CH_N*DATA_W  packed pixel.
- i_hsync  in  1  horizontal sync.
- i_vsync  in  1  vertical sync.
- i_de  in  1  data enable; high marks an active pixel.
- i_win_en  in  1  1 = windowed minimum, 0 = per-pixel minimum only. Sampled with the pixel.
- o_dark  out  DATA_W  dark-channel value.
- o_hsync  out  1  i_hsync delayed 2 cycles.
- o_vsync  out  1  i_vsync delayed 2 cycles.
- o_de  out  1  i_de delayed 2 cycles.

Behaviour:
- Reset (async assert, sync release): o_dark, o_hsync, o_vsync, o_de = 0. Stage registers = 0. Window history = all-ones (2^DATA_W-1).
- Stage 1, edge 1 after input:
  - s1_min = unsigned minimum of the CH_N channels; ties give the equal value.
  - s1_de, s1_hs, s1_vs, s1_win = the sampled inputs.
- History shift register hist[0..WIN-2], updated on every edge:
  - If s1_de = 1: hist[0] <= s1_min, hist[k] <= hist[k-1].
  - If s1_de = 0: all entries <= all-ones. Any de-low cycle, including a mid-line gap, therefore starts a new line, and pixels never mix across lines.
  - Required: de low for at least 1 cycle between lines.
- Stage 2, edge 2 after input:
  - If s1_win = 1: o_dark <= min(s1_min, hist[0..WIN-2]). Missing history at line start is all-ones, so it never wins.
  - If s1_win = 0, or WIN = 1: o_dark <= s1_min.
  - If s1_de = 0: o_dark <= 0.
  - o_de/o_hsync/o_vsync <= s1 versions.
- Latency: fixed 2 cycles for data and syncs in both modes. Throughput is 1 pixel per clock, with no backpressure.
- Window semantics: trailing window. Output for pixel n = min(pmin[max(line_start, n-WIN+1) .. n]).
- i_win_en may change mid-line. Each pixel uses its own sampled value, and history keeps updating in either mode.
- Reset mid-line: outputs clear immediately and history is refilled with all-ones. The first line after release is processed as a fresh line.
- Minimum logic is a balanced compare tree of depth ceil(log2(WIN)), registered once. No intermediate pipelining is required for WIN <= 15 at the target pixel rate.
- Elaboration error if WIN < 1, WIN > 15, CH_N < 2 or CH_N > 4.

Decomposition:
- Package dark_pkg:
  - DATA_W default, MAX_WIN = 15.
  - All-ones constant function by width.
  - Function min2 for unsigned DATA_W compare.
- Sub-module chan_min: combinational CH_N-way minimum of the packed pixel. Instantiated once in stage 1 and reusable by later blocks.
- Window shift register and compare tree stay in the top.

Test Plan (DATA_W=8, CH_N=3, WIN=3 unless noted):
- Reset: hold reset_n low while driving active pixels -> o_dark, o_de, o_hsync, o_vsync = 0. Assert reset_n mid-line -> outputs go 0 without waiting for a clock edge.
- Per-pixel mode: i_win_en=0, pixel (R,G,B) = (0x80,0x20,0x40), then (0x10,0x10,0x50) -> o_dark = 0x20 then 0x10, exactly 2 cycles after each input, with o_de = 1.
- Window: i_win_en=1, one line with per-pixel minima 50,30,70,90,10,60 -> o_dark = 50,30,30,30,10,10. o_de high for exactly 6 cycles, delayed by 2.
- Line boundary: after that line, de low 1 cycle, then first pixel min 0xC0, second 0xD0 -> o_dark = 0xC0, 0xC0 (not 10 or 60). o_dark = 0 during the gap.
- Sync alignment: i_hsync/i_vsync pulses at arbitrary cycles, including during de = 0 -> identical pulses on o_hsync/o_vsync delayed exactly 2 cycles.
- WIN=1 and WIN=15 builds: random frame checked against a reference model of the trailing-window minimum with line reset -> zero mismatches. Mode toggled mid-line -> each pixel matches the mode it was sampled with.
